// File: rtl/mod12_display_driver_pkg.sv
// Shared constants and types for the mod-12 two-digit display driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package mod12_disp_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [3:0] MOD12_MAX = 4'd11;

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment decoder; dash takes priority over blank,
// and non-decimal digits decode as blank.
module seg7_decoder
  import mod12_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Pattern select: dash, blank or decimal glyph.
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_DIGIT[0];
        4'd1:    seg_o = SEG_DIGIT[1];
        4'd2:    seg_o = SEG_DIGIT[2];
        4'd3:    seg_o = SEG_DIGIT[3];
        4'd4:    seg_o = SEG_DIGIT[4];
        4'd5:    seg_o = SEG_DIGIT[5];
        4'd6:    seg_o = SEG_DIGIT[6];
        4'd7:    seg_o = SEG_DIGIT[7];
        4'd8:    seg_o = SEG_DIGIT[8];
        4'd9:    seg_o = SEG_DIGIT[9];
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/mod12_display_driver.sv
// Two-digit multiplexed 7-segment driver for a mod-12 counter value,
// with per-frame snapshot, 11->0 rollover pulse and out-of-range flag.
module mod12_display_driver
  import mod12_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       rollover,
  output logic       err
);

  localparam int              PRE_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [3:0]       count_q, disp_q, disp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  scan_state_e      state_q, state_d;
  logic             first_q;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             rollover_q, rollover_d;
  logic             err_q, err_d;

  logic             tick_s;
  logic [3:0]       tens_s, units_s, sel_digit_s;
  logic             sel_blank_s, dash_s;
  logic [6:0]       pat_s;

  // Prescaler, scan FSM next state and frame snapshot.
  always_comb begin
    tick_s  = (pre_q == PRE_MAX);
    pre_d   = tick_s ? '0 : pre_q + PRE_W'(1);
    state_d = state_q;
    case (state_q)
      UNITS: begin
        if (tick_s) state_d = TENS;
        else        state_d = UNITS;
      end
      TENS: begin
        if (tick_s) state_d = UNITS;
        else        state_d = TENS;
      end
      default: state_d = UNITS;
    endcase
    // Snapshot only between frames so a frame never mixes two values.
    if (first_q || (state_q == TENS && tick_s)) begin
      disp_d = count_q;
    end else begin
      disp_d = disp_q;
    end
  end

  // Digit split, selected-digit mux and output-register next values.
  always_comb begin
    dash_s = (disp_q > MOD12_MAX);
    if (disp_q >= 4'd10) begin
      tens_s  = 4'd1;
      units_s = disp_q - 4'd10;
    end else begin
      tens_s  = 4'd0;
      units_s = disp_q;
    end
    if (state_q == TENS) begin
      sel_digit_s = tens_s;
      sel_blank_s = BLANK_LZ && (tens_s == 4'd0);
      an_d        = 2'b10;
    end else begin
      sel_digit_s = units_s;
      sel_blank_s = 1'b0;
      an_d        = 2'b01;
    end
    seg_d      = SEG_ACTIVE_LOW ? ~pat_s : pat_s;
    rollover_d = (count_q == MOD12_MAX) && (count == 4'd0);
    err_d      = dash_s;
  end

  seg7_decoder u_dec (
    .digit_i (sel_digit_s),
    .blank_i (sel_blank_s),
    .dash_i  (dash_s),
    .seg_o   (pat_s)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= 4'd0;
      disp_q     <= 4'd0;
      pre_q      <= '0;
      state_q    <= UNITS;
      first_q    <= 1'b1;
      seg_q      <= SEG_OFF;
      an_q       <= 2'b00;
      rollover_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count;
      disp_q     <= disp_d;
      pre_q      <= pre_d;
      state_q    <= state_d;
      first_q    <= 1'b0;
      seg_q      <= seg_d;
      an_q       <= an_d;
      rollover_q <= rollover_d;
      err_q      <= err_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign rollover = rollover_q;
  assign err      = err_q;

endmodule

// File: doc/mod12_display_driver.md
# mod12_display_driver

Downstream consumer of the mod-12 counter's 4-bit `count` output. It registers the count and splits it into tens and units digits (0–11 → "0".."11"). It drives a time-multiplexed two-digit common-anode-select 7-segment display and emits a one-cycle pulse each time the counter wraps from 11 to 0. All outputs are registered; input values 12–15 display as "--" and raise an error flag.

## Interface
Parameters:
- `REFRESH_DIV`, default 4: clock cycles each digit stays selected; legal range ≥ 2.
- `BLANK_LZ`, default 1: when 1, the tens digit is blanked when it is 0.
- `SEG_ACTIVE_LOW`, default 0: when 1, `seg` is inverted at the output register. `an` is unaffected.

Ports:
- `clock`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `count`: input, 4 bits. Value from the mod-12 counter.
- `seg`: output, 7 bits. Segment pattern `{g,f,e,d,c,b,a}`, active-high when `SEG_ACTIVE_LOW`=0.
- `an`: output, 2 bits. Digit select, one-hot active-high. `an[0]` is units, `an[1]` is tens.
- `rollover`: output, 1 bit. One-cycle pulse on an 11→0 transition.
- `err`: output, 1 bit. High while the frame snapshot holds a value > 11.

## Operation
- **Input stage:** `count_q` loads `count` every cycle.
- **Rollover:** `rollover` is registered as (`count_q`==11 && `count`==0).
  - Any other transition does not pulse, including 5→0, 11→11 and 11→3.
  - A `load` of 0 while the counter is at 11 does pulse; this is intended.
- **Prescaler:** `pre` counts 0..`REFRESH_DIV`-1 and wraps. `tick` = (`pre`==`REFRESH_DIV`-1).
- **Scan FSM:** two states, UNITS and TENS.
  - UNITS→TENS on `tick`.
  - TENS→UNITS on `tick`.
  - There are no other transitions.
- **Frame snapshot:** `disp` loads `count_q` on the tick that transitions TENS→UNITS, and also on the first cycle after reset release. This prevents tearing mid-frame.
- **Digit split** (from `disp`):
  - Values 0–9: tens=0, units=`disp`.
  - Values 10–11: tens=1, units=`disp`-10.
  - Values 12–15: both digits show dash (0x40) and `err`=1.
- **Decode patterns:**
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Blank=0x00.
  - Tens digit with value 0 and `BLANK_LZ`=1 shows blank. `an[1]` is still asserted in that case.
- **Output register:**
  - `an` = 2'b01 in UNITS, 2'b10 in TENS.
  - `seg` = pattern of the selected digit.

## Timing
- **Reset (asynchronous):**
  - `count_q`=0, `disp`=0, `pre`=0, state=UNITS.
  - Outputs: `an`=00, `seg`=all segments off (0x00, or 0x7F if `SEG_ACTIVE_LOW`), `rollover`=0, `err`=0.
- **After reset release:**
  - First rising edge: `disp` is loaded and the output register receives units pattern and `an`=01.
  - `an` stays 01 for `REFRESH_DIV` cycles, then 10 for `REFRESH_DIV` cycles, repeating. Frame = 2·`REFRESH_DIV` cycles.
- **Latency:**
  - `count` change at edge N appears in `count_q` at edge N+1.
  - It appears on the display from the next frame boundary at or after N+1, plus 1 cycle for the output register.
- **`rollover` timing:** the counter drives 0 after edge N, and `rollover`=1 during the cycle following edge N+1. It is exactly one cycle wide.
- **Simultaneous events:** a rollover coinciding with a frame boundary is handled independently; the snapshot takes the pre-edge `count_q`.
- **Reset mid-frame:** outputs blank immediately (asynchronous). The scan restarts in UNITS with `pre`=0; no partial frame persists.

## Structure
- **Package `mod12_disp_pkg`:**
  - Constants: `SEG_DIGIT[0:9]`, `SEG_BLANK`, `SEG_DASH`, `MOD12_MAX`=11.
  - State type: UNITS/TENS.
- **Sub-module `seg7_decoder`:**
  - Combinational: 4-bit digit plus blank/dash controls in, 7-bit pattern out.
  - Instantiated once, fed by a mux of the selected digit.
- Everything else lives in the top module.

## Test plan
Use `REFRESH_DIV`=4, `BLANK_LZ`=1, `SEG_ACTIVE_LOW`=0.
1. **Reset:** assert `reset` mid-cycle → `an`=00, `seg`=0x00, `rollover`=0 with no clock edge. Release → `an` sequence 01×4, 10×4, repeating.
2. **Static 7:** hold `count`=7 → units phase `seg`=0x07; tens phase `seg`=0x00 (blanked). `err`=0.
3. **Static 11:** hold `count`=11 → units phase `seg`=0x06, tens phase `seg`=0x06. Hold `count`=10 → units 0x3F, tens 0x06.
4. **Wrap:** step `count` 10, 11, 0, 1 on consecutive cycles → exactly one `rollover` pulse, in the cycle after `count_q` becomes 0. Sequence 5→0 → no pulse.
5. **Invalid:** hold `count`=13 → after the next frame boundary both digits show 0x40 and `err`=1. `count`=3 → `err` clears at the following frame boundary.
6. **Tearing:** change `count` from 9 to 10 during the TENS phase → current frame is unchanged (tens blank). Next frame shows units 0x3F, tens 0x06.
